// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller driving the PC enable,
// per-register enables and NOP-bubble injection from four hazard sources.
//
// Ports:
//   i_clk              clock, all state on rising edge
//   i_reset            synchronous active-low reset (flushes pipe with NOPs)
//   i_icache_miss      instruction cache blocking
//   i_dcache_miss      data cache blocking (freezes the whole pipe)
//   i_dec_rs_a/_b      source registers of the instruction in decode
//   i_dec_uses_a/_b    decode really reads rs_a / rs_b
//   i_dec_is_multicycle decode instruction needs MUL_LATENCY ALU cycles
//   i_ex_is_load       ALU-stage instruction is a load
//   i_ex_rd            ALU-stage destination register
//   i_branch_taken     ALU stage resolved a taken branch
//   o_pc_en            PC load enable
//   o_reg_en           inter-stage register enables (k = stage k -> k+1)
//   o_bubble           register k loads a NOP instead of its input
//   o_stall_cause      0 none, 1 dcache, 2 multicycle, 3 branch, 4 load-use, 5 icache
//   o_mc_busy          multicycle op occupying the ALU stage
//   o_perf_stall_cnt   saturating count of cycles with o_pc_en = 0
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES  = 5,
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 5,
    parameter int PERF_W      = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_icache_miss,
    input  logic                    i_dcache_miss,
    input  logic [REG_ADDR_W-1:0]   i_dec_rs_a,
    input  logic [REG_ADDR_W-1:0]   i_dec_rs_b,
    input  logic                    i_dec_uses_a,
    input  logic                    i_dec_uses_b,
    input  logic                    i_dec_is_multicycle,
    input  logic                    i_ex_is_load,
    input  logic [REG_ADDR_W-1:0]   i_ex_rd,
    input  logic                    i_branch_taken,
    output logic                    o_pc_en,
    output logic [NUM_STAGES-2:0]   o_reg_en,
    output logic [NUM_STAGES-2:0]   o_bubble,
    output logic [2:0]              o_stall_cause,
    output logic                    o_mc_busy,
    output logic [PERF_W-1:0]       o_perf_stall_cnt
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam bit MC_EN = MUL_LATENCY > 1;

    typedef enum logic {
        IDLE,
        MC_BUSY
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PERF_W-1:0] r_perf;
    logic              w_load_use;
    logic              w_mc_start;

    // a load to r0 never creates a dependency
    assign w_load_use = i_ex_is_load && (i_ex_rd != '0) &&
                        ((i_dec_uses_a && (i_dec_rs_a == i_ex_rd)) ||
                         (i_dec_uses_b && (i_dec_rs_b == i_ex_rd)));

    // a real (non-bubble) instruction is being clocked into D/A
    assign w_mc_start = MC_EN && o_reg_en[1] && !o_bubble[1] && i_dec_is_multicycle;

    assign o_perf_stall_cnt = r_perf;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_perf  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!o_pc_en && (r_perf != '1))
                r_perf <= r_perf + PERF_W'(1);
        end
    end

    // priority-ordered hazard resolution; only the winning cause acts
    always_comb begin
        o_pc_en       = 1'b1;
        o_reg_en      = '1;
        o_bubble      = '0;
        o_stall_cause = 3'd0;
        o_mc_busy     = 1'b0;
        if (!i_reset) begin
            o_pc_en  = 1'b0;
            o_bubble = '1;
        end else if (i_dcache_miss) begin
            o_pc_en       = 1'b0;
            o_reg_en      = '0;
            o_stall_cause = 3'd1;
            o_mc_busy     = r_state == MC_BUSY;
        end else if (r_state == MC_BUSY) begin
            // hold F/D and D/A, feed NOPs behind the op still in the ALU
            o_pc_en       = 1'b0;
            o_reg_en[0]   = 1'b0;
            o_reg_en[1]   = 1'b0;
            o_bubble[2]   = 1'b1;
            o_stall_cause = 3'd2;
            o_mc_busy     = 1'b1;
        end else if (i_branch_taken) begin
            o_bubble[0]   = 1'b1;
            o_bubble[1]   = 1'b1;
            o_stall_cause = 3'd3;
        end else if (w_load_use) begin
            o_pc_en       = 1'b0;
            o_reg_en[0]   = 1'b0;
            o_bubble[1]   = 1'b1;
            o_stall_cause = 3'd4;
        end else if (i_icache_miss) begin
            o_pc_en       = 1'b0;
            o_bubble[0]   = 1'b1;
            o_stall_cause = 3'd5;
        end
    end

    // multicycle FSM: counter freezes while the data cache blocks the pipe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == IDLE) begin
            if (w_mc_start) begin
                w_state_nxt = MC_BUSY;
                w_cnt_nxt   = MC_LOAD;
            end
        end else if (!i_dcache_miss) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE)
                w_state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a behavioural hazard model.
module tb_pipe_hazard_ctrl;

    localparam int L    = 5;
    localparam int PW   = 4;
    localparam int PMAX = (1 << PW) - 1;

    logic       clk = 1'b0;
    logic       rst_n, ic, dc, ua, ub, mc, ld, br;
    logic [4:0] rs_a, rs_b, rd;
    logic       pc_en, mc_busy;
    logic [3:0] reg_en, bubble;
    logic [2:0] cause;
    logic [PW-1:0] perf;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_ADDR_W(5), .MUL_LATENCY(L), .PERF_W(PW)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_icache_miss(ic), .i_dcache_miss(dc),
        .i_dec_rs_a(rs_a), .i_dec_rs_b(rs_b), .i_dec_uses_a(ua), .i_dec_uses_b(ub),
        .i_dec_is_multicycle(mc), .i_ex_is_load(ld), .i_ex_rd(rd), .i_branch_taken(br),
        .o_pc_en(pc_en), .o_reg_en(reg_en), .o_bubble(bubble), .o_stall_cause(cause),
        .o_mc_busy(mc_busy), .o_perf_stall_cnt(perf)
    );

    typedef struct {
        bit       rst, ic, dc, ua, ub, mc, ld, br;
        bit [4:0] rs_a, rs_b, rd;
    } stim_t;

    typedef struct {
        bit       pc;
        bit [3:0] en, bub;
        int       cause;
        bit       busy;
        int       perf;
    } exp_t;

    exp_t exp_q[$];
    int   m_busy_left = 0;
    int   m_perf = 0;
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", n, act, req, $time);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst = 1;
        return s;
    endfunction

    function automatic exp_t predict(stim_t s);
        exp_t e;
        bit   lu;
        lu = s.ld && s.rd != 0 && ((s.ua && s.rs_a == s.rd) || (s.ub && s.rs_b == s.rd));
        e.perf = m_perf;
        e.busy = s.rst && m_busy_left > 0;
        if (!s.rst)                e = '{0, 4'hF, 4'hF, 0, 0, m_perf};
        else if (s.dc)             e = '{0, 4'h0, 4'h0, 1, m_busy_left > 0, m_perf};
        else if (m_busy_left > 0)  e = '{0, 4'b1100, 4'b0100, 2, 1, m_perf};
        else if (s.br)             e = '{1, 4'hF, 4'b0011, 3, 0, m_perf};
        else if (lu)               e = '{0, 4'b1110, 4'b0010, 4, 0, m_perf};
        else if (s.ic)             e = '{0, 4'hF, 4'b0001, 5, 0, m_perf};
        else                       e = '{1, 4'hF, 4'h0, 0, 0, m_perf};
        return e;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = s.rst; ic = s.ic; dc = s.dc; ua = s.ua; ub = s.ub; mc = s.mc;
        ld = s.ld; br = s.br; rs_a = s.rs_a; rs_b = s.rs_b; rd = s.rd;
        e = predict(s);
        exp_q.push_back(e);
        if (!s.rst) begin
            m_busy_left = 0;
            m_perf = 0;
        end else begin
            if (!e.pc) m_perf = (m_perf < PMAX) ? m_perf + 1 : PMAX;
            if (m_busy_left > 0) begin
                if (!s.dc) m_busy_left--;
            end else if (e.en[1] && !e.bub[1] && s.mc && L > 1)
                m_busy_left = L - 1;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_en", 32'(pc_en), 32'(e.pc));
            chk("reg_en", 32'(reg_en), 32'(e.en));
            chk("bubble", 32'(bubble), 32'(e.bub));
            chk("stall_cause", 32'(cause), e.cause);
            chk("mc_busy", 32'(mc_busy), 32'(e.busy));
            chk("perf_stall_cnt", 32'(perf), e.perf);
        end
    end

    initial begin
        stim_t s;
        rst_n = 0; ic = 0; dc = 0; ua = 0; ub = 0; mc = 0; ld = 0; br = 0;
        rs_a = 0; rs_b = 0; rd = 0;
        s = idle(); s.rst = 0;
        repeat (2) step(s);
        repeat (3) step(idle());
        s = idle(); s.ld = 1; s.rd = 7; s.rs_a = 7; s.ua = 1;
        step(s);
        step(idle());
        s.rd = 0; s.rs_a = 0;
        step(s);
        step(idle());
        s = idle(); s.mc = 1;
        step(s);
        repeat (6) step(idle());
        step(s);
        step(idle());
        s = idle(); s.dc = 1;
        repeat (3) step(s);
        repeat (6) step(idle());
        s = idle(); s.br = 1; s.ic = 1;
        step(s);
        s = idle(); s.mc = 1;
        step(s);
        repeat (2) step(idle());
        s = idle(); s.rst = 0;
        step(s);
        repeat (2) step(idle());
        s = idle(); s.ic = 1;
        repeat (20) step(s);
        step(idle());
        for (int i = 0; i < 3000; i++) begin
            s.rst  = $urandom_range(0, 63) != 0;
            s.dc   = $urandom_range(0, 7) == 0;
            s.ic   = $urandom_range(0, 5) == 0;
            s.br   = $urandom_range(0, 7) == 0;
            s.ld   = $urandom_range(0, 2) == 0;
            s.mc   = $urandom_range(0, 4) == 0;
            s.ua   = 1'($urandom);
            s.ub   = 1'($urandom);
            s.rd   = 5'($urandom_range(0, 3));
            s.rs_a = 5'($urandom_range(0, 3));
            s.rs_b = 5'($urandom_range(0, 3));
            step(s);
        end
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
